// File: rtl/shift_job_scheduler_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the shift job scheduler.
package shift_sched_pkg;

   localparam int unsigned SCHED_N  = 4;
   localparam int unsigned SCHED_W  = 8;
   localparam int unsigned SCHED_SW = 3;
   localparam int unsigned IDW      = $clog2(SCHED_N);

   // Upper bound on requester count handled by rr_pick; callers zero-extend into this width.
   localparam int unsigned RR_MAX_N = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      OUT   = 2'd3
   } state_t;

   // First set request scanning last+1, last+2, ... (mod n); returns last when nothing is set.
   function automatic int unsigned rr_pick(input logic [RR_MAX_N-1:0] req,
                                           input int unsigned         last,
                                           input int unsigned         n,
                                           output logic               found);
      int unsigned idx;
      int unsigned pick;
      pick  = last;
      found = 1'b0;
      for (int unsigned k = 0; k < RR_MAX_N; k++) begin
         idx = last + 1 + k;
         if (idx >= n) idx = idx - n;
         if ((k < n) && !found && ((req & (RR_MAX_N'(1) << idx)) != '0)) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/shift_job_scheduler_if.sv
// Request/grant and result handshake bundle between clients and the shift job scheduler.
interface shift_job_scheduler_if
   import shift_sched_pkg::*;
#(
   parameter int unsigned N  = SCHED_N,
   parameter int unsigned W  = SCHED_W,
   parameter int unsigned SW = SCHED_SW
);
   localparam int unsigned ID_W = $clog2(N);

   logic [N-1:0]    req;
   logic [N*W-1:0]  req_data;
   logic [N*SW-1:0] req_shamt;
   logic [N-1:0]    gnt;
   logic            busy;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_data;
   logic [ID_W-1:0] out_id;

   modport master (
      output req, req_data, req_shamt, out_ready,
      input  gnt, busy, out_valid, out_data, out_id
   );

   modport slave (
      input  req, req_data, req_shamt, out_ready,
      output gnt, busy, out_valid, out_data, out_id
   );

endinterface

// File: rtl/shift_job_scheduler_step_unit.sv
// Shared datapath register: parallel load or logical shift-left by one, zero fill.
module shift_step_unit
   import shift_sched_pkg::*;
#(
   parameter int unsigned W = SCHED_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shl1,
   input  logic [W-1:0] din,
   output logic [W-1:0] q
);

   logic [W-1:0] sreg_q, sreg_d;

   // Load has priority over shift; otherwise hold.
   always_comb begin
      sreg_d = sreg_q;
      if (load) begin
         sreg_d = din;
      end else if (shl1) begin
         sreg_d = sreg_q << 1;
      end
   end

   // Datapath register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_q <= '0;
      end else begin
         sreg_q <= sreg_d;
      end
   end

   assign q = sreg_q;

endmodule

// File: rtl/shift_job_scheduler.sv
// Round-robin scheduler sharing one load/shift/output datapath between N requesters.
module shift_job_scheduler
   import shift_sched_pkg::*;
#(
   parameter int unsigned N  = SCHED_N,
   parameter int unsigned W  = SCHED_W,
   parameter int unsigned SW = SCHED_SW
) (
   input  logic                   clk,
   input  logic                   rst,
   shift_job_scheduler_if.slave   bus
);

   localparam int unsigned ID_W = $clog2(N);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [W-1:0]      data_q, data_d;
   logic [SW-1:0]     shamt_q, shamt_d;
   logic [SW-1:0]     cnt_q, cnt_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic              out_valid_q, out_valid_d;
   logic [W-1:0]      out_data_q, out_data_d;
   logic [ID_W-1:0]   out_id_q, out_id_d;

   logic              load;
   logic              shl1;
   logic [W-1:0]      sreg;
   logic [RR_MAX_N-1:0] req_ext;
   logic [ID_W-1:0]   nxt_id;
   logic              pick_found;

   shift_step_unit #(
      .W(W)
   ) u_step (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .shl1 (shl1),
      .din  (data_q),
      .q    (sreg)
   );

   // Next-state, capture and output-register logic for IDLE -> LOAD -> SHIFT* -> OUT.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      data_d      = data_q;
      shamt_d     = shamt_q;
      cnt_d       = cnt_q;
      gnt_d       = '0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      load        = 1'b0;
      shl1        = 1'b0;

      req_ext          = '0;
      req_ext[N-1:0]   = bus.req;
      pick_found       = 1'b0;
      nxt_id           = ID_W'(rr_pick(req_ext, 32'(last_q), N, pick_found));

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               id_d    = nxt_id;
               last_d  = nxt_id;
               data_d  = W'(bus.req_data >> (32'(nxt_id) * W));
               shamt_d = SW'(bus.req_shamt >> (32'(nxt_id) * SW));
               gnt_d   = N'(1) << nxt_id;
               state_d = LOAD;
            end
         end
         LOAD: begin
            load  = 1'b1;
            cnt_d = shamt_q;
            state_d = (shamt_q == '0) ? OUT : SHIFT;
         end
         SHIFT: begin
            shl1  = 1'b1;
            cnt_d = cnt_q - SW'(1);
            if (cnt_q == SW'(1)) begin
               state_d = OUT;
            end
         end
         OUT: begin
            // First OUT cycle registers the result; later cycles wait for the handshake.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = sreg;
               out_id_d    = id_q;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pointer, capture and output registers; reset discards any in-flight job.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= ID_W'(N - 1);
         id_q        <= '0;
         data_q      <= '0;
         shamt_q     <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         id_q        <= id_d;
         data_q      <= data_d;
         shamt_q     <= shamt_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_shift_job_scheduler.sv
// Directed self-checking bench for shift_job_scheduler (N=4, W=8, SW=3).
module tb_shift_job_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned SW = 3;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   shift_job_scheduler_if #(.N(N), .W(W), .SW(SW)) bus();

   shift_job_scheduler #(.N(N), .W(W), .SW(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
      chk({tag, "_data"},  32'(bus.out_data),  32'(d));
      chk({tag, "_id"},    32'(bus.out_id),    32'(id));
   endtask

   task automatic set_job(input int unsigned i, input logic [W-1:0] d, input logic [SW-1:0] s);
      bus.req_data[i*W +: W]    = d;
      bus.req_shamt[i*SW +: SW] = s;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [7:0] t2_data [4];

   initial begin
      rst           = 1'b1;
      bus.req       = '0;
      bus.req_data  = '0;
      bus.req_shamt = '0;
      bus.out_ready = 1'b1;
      t2_data       = '{8'h11, 8'h22, 8'h33, 8'h44};

      // Reset state
      do_reset();
      chk("rst_gnt",  32'(bus.gnt),  32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk_out("rst", 1'b0, 8'h00, 2'd0);

      // 1: single job, shamt=1
      set_job(0, 8'h35, 3'd1);
      bus.req = 4'b0001;
      tick();
      chk("t1_gnt",  32'(bus.gnt),  32'h1);
      chk("t1_busy", 32'(bus.busy), 32'h1);
      bus.req = '0;
      tick();
      chk("t1_gnt_pulse", 32'(bus.gnt), 32'h0);
      chk("t1_v1", 32'(bus.out_valid), 32'h0);
      tick();
      chk("t1_v2", 32'(bus.out_valid), 32'h0);
      tick();
      chk_out("t1_res", 1'b1, 8'h6A, 2'd0);
      tick();
      chk_out("t1_hold", 1'b0, 8'h6A, 2'd0);
      chk("t1_idle", 32'(bus.busy), 32'h0);

      // 2: four simultaneous requesters, shamt=0, RR from requester 0
      do_reset();
      chk("t2_rst_data", 32'(bus.out_data), 32'h0);
      for (int j = 0; j < 4; j++) set_job(j, t2_data[j], 3'd0);
      bus.req = 4'b1111;
      for (int j = 0; j < 4; j++) begin
         tick();
         chk("t2_gnt", 32'(bus.gnt), 32'(1) << j);
         bus.req[j] = 1'b0;
         tick();
         chk("t2_v_early", 32'(bus.out_valid), 32'h0);
         tick();
         chk_out("t2_res", 1'b1, t2_data[j], 2'(j));
         tick();
         chk("t2_v_done", 32'(bus.out_valid), 32'h0);
      end

      // 3: shamt=7 boundary, 0x81 and 0xFF both give 0x80
      set_job(0, 8'h81, 3'd7);
      bus.req = 4'b0001;
      tick();
      chk("t3a_gnt", 32'(bus.gnt), 32'h1);
      bus.req = '0;
      repeat (7) tick();
      tick();
      chk("t3a_v8", 32'(bus.out_valid), 32'h0);
      tick();
      chk_out("t3a_res", 1'b1, 8'h80, 2'd0);
      tick();
      chk("t3a_done", 32'(bus.out_valid), 32'h0);

      set_job(2, 8'hFF, 3'd7);
      bus.req = 4'b0100;
      tick();
      chk("t3b_gnt", 32'(bus.gnt), 32'h4);
      bus.req = '0;
      repeat (8) tick();
      chk("t3b_v8", 32'(bus.out_valid), 32'h0);
      tick();
      chk_out("t3b_res", 1'b1, 8'h80, 2'd2);
      tick();
      chk("t3b_done", 32'(bus.out_valid), 32'h0);

      // 4: back-pressure in OUT with a pending request
      bus.out_ready = 1'b0;
      set_job(0, 8'hA5, 3'd2);
      bus.req = 4'b0001;
      tick();
      chk("t4_gnt0", 32'(bus.gnt), 32'h1);
      set_job(1, 8'h3C, 3'd0);
      bus.req = 4'b0010;
      tick();
      tick();
      tick();
      chk("t4_v3", 32'(bus.out_valid), 32'h0);
      tick();
      chk_out("t4_res", 1'b1, 8'h94, 2'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_out("t4_stall", 1'b1, 8'h94, 2'd0);
         chk("t4_stall_gnt", 32'(bus.gnt), 32'h0);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("t4_hs_valid", 32'(bus.out_valid), 32'h0);
      chk("t4_hs_gnt",   32'(bus.gnt),       32'h0);
      tick();
      chk("t4_gnt1", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      tick();
      tick();
      chk_out("t4_res1", 1'b1, 8'h3C, 2'd1);
      tick();
      chk("t4_done", 32'(bus.out_valid), 32'h0);

      // 5: reset during SHIFT discards the job and restores the pointer
      set_job(1, 8'h0F, 3'd5);
      bus.req = 4'b0010;
      tick();
      chk("t5_gnt", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      tick();
      tick();
      chk("t5_busy", 32'(bus.busy), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_busy", 32'(bus.busy), 32'h0);
      chk("t5_rst_gnt",  32'(bus.gnt),  32'h0);
      chk_out("t5_rst", 1'b0, 8'h00, 2'd0);
      set_job(1, 8'h09, 3'd1);
      set_job(3, 8'h77, 3'd0);
      bus.req = 4'b1010;
      tick();
      chk("t5_gnt_after", 32'(bus.gnt), 32'h2);
      bus.req = 4'b1000;
      tick();
      tick();
      tick();
      chk_out("t5_res1", 1'b1, 8'h12, 2'd1);
      tick();
      chk("t5_done1", 32'(bus.out_valid), 32'h0);
      tick();
      chk("t5_gnt3", 32'(bus.gnt), 32'h8);
      bus.req = '0;
      tick();
      tick();
      chk_out("t5_res3", 1'b1, 8'h77, 2'd3);
      tick();
      chk("t5_done3", 32'(bus.out_valid), 32'h0);

      // 6: RR wraps from last=2 to requester 0 ahead of a repeat request from 2
      set_job(2, 8'h01, 3'd3);
      bus.req = 4'b0100;
      tick();
      chk("t6_gnt2", 32'(bus.gnt), 32'h4);
      set_job(0, 8'h40, 3'd0);
      bus.req = 4'b0101;
      repeat (4) tick();
      chk("t6_v4", 32'(bus.out_valid), 32'h0);
      tick();
      chk_out("t6_res2", 1'b1, 8'h08, 2'd2);
      tick();
      chk("t6_done2", 32'(bus.out_valid), 32'h0);
      tick();
      chk("t6_gnt0", 32'(bus.gnt), 32'h1);
      bus.req = 4'b0100;
      tick();
      tick();
      chk_out("t6_res0", 1'b1, 8'h40, 2'd0);
      tick();
      chk("t6_done0", 32'(bus.out_valid), 32'h0);
      tick();
      chk("t6_gnt2b", 32'(bus.gnt), 32'h4);
      bus.req = '0;
      repeat (4) tick();
      tick();
      chk_out("t6_res2b", 1'b1, 8'h08, 2'd2);
      tick();
      chk("t6_done2b", 32'(bus.out_valid), 32'h0);
      chk("t6_idle",   32'(bus.busy),      32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
